// File: rtl/mux2_share_arbiter_if.sv
// mux2_share_arbiter_if: request/data inputs and grant/mux outputs of the shared 2:1 channel
interface mux2_share_arbiter_if #(parameter int WIDTH = 8);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  modport master (output req0, req1, in0, in1, input gnt0, gnt1, sel, out, out_valid);
  modport slave (input req0, req1, in0, in1, output gnt0, gnt1, sel, out, out_valid);
endinterface

// File: rtl/mux2_share_arbiter.sv
// mux2_share_arbiter: round-robin owner of a 2:1 mux with a per-source burst limit
module mux2_share_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic                clock,
  input logic                reset,
  mux2_share_arbiter_if.slave bus
);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            last, last_n;
  logic            sel_q, sel_n;
  logic [WIDTH-1:0] mux;
  logic            full;
  assign full = cnt == MAXC;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
      sel_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      last  <= last_n;
      sel_q <= sel_n;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (bus.req0 && bus.req1) ? (last ? G0 : G1) :
                         bus.req0 ? G0 : bus.req1 ? G1 : IDLE;
      G0:      state_n = !bus.req0 ? (bus.req1 ? G1 : IDLE) : (full && bus.req1) ? G1 : G0;
      G1:      state_n = !bus.req1 ? (bus.req0 ? G0 : IDLE) : (full && bus.req0) ? G0 : G1;
      default: state_n = IDLE;
    endcase
    // a new owner restarts the burst; a lone owner wraps back to 1 instead of overflowing
    cnt_n  = (state_n == IDLE) ? '0 :
             (state_n != state) ? CW'(1) : full ? CW'(1) : cnt + 1'b1;
    last_n = (state_n != state && state_n != IDLE) ? (state_n == G1) : last;
    sel_n  = (state_n != state && state_n != IDLE) ? (state_n == G1) : sel_q;
  end
  assign mux           = sel_q ? bus.in1 : bus.in0;
  assign bus.out       = mux;
  assign bus.sel       = sel_q;
  assign bus.gnt0      = state == G0;
  assign bus.gnt1      = state == G1;
  assign bus.out_valid = state != IDLE;
endmodule

// File: doc/mux2_share_arbiter.md
Name: mux2_share_arbiter

Overview:
- Round-robin arbiter that shares a single 2:1 mux output channel between two requesters (source 0 on in0, source 1 on in1).
- Owns the mux select and issues one-hot grants.
- Bounds each source's occupancy with a burst counter so a continuously requesting source cannot starve the other.
- Sits in front of the shared mux; downstream logic samples out when out_valid is high.

Parameters:
- WIDTH, 8, data width of in0/in1/out.
- MAX_BURST, 4, maximum consecutive granted cycles per source while the other source is requesting. Legal range is 1 or greater.

Ports:
- clock  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  source 0 requests the channel; held high while it wants service.
- req1  input  1  source 1 requests the channel.
- in0  input  WIDTH  source 0 data.
- in1  input  WIDTH  source 1 data.
- gnt0  output  1  source 0 owns the channel (registered).
- gnt1  output  1  source 1 owns the channel (registered).
- sel  output  1  mux select: 0 selects in0, 1 selects in1 (registered).
- out  output  WIDTH  shared channel data, sel ? in1 : in0 (combinational from registered sel).
- out_valid  output  1  gnt0 | gnt1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (ports clock, reset).
- Reset, immediate on assertion and independent of clock:
  - state=IDLE, gnt0=0, gnt1=0, sel=0, out_valid=0, cnt=0.
  - last=1 (last-served pointer, so source 0 wins the first tie).
  - Reset mid-grant drops the grant immediately; no completion of the burst.
- States: IDLE, G0, G1. gnt0=1 only in G0, gnt1=1 only in G1; never both.
- sel=0 in G0, 1 in G1; holds its previous value in IDLE. out is therefore stable between grants.
- Latency: a request seen at edge N produces a grant visible after edge N; req to gnt is 1 cycle.
- IDLE transitions:
  - req0 & req1: go to the source with index != last.
  - req0 only: G0.
  - req1 only: G1.
  - Neither: stay in IDLE.
- Entering Gx: cnt=1, last=x, sel=x.
- G0 (G1 is symmetric):
  - !req0 and req1: go to G1 directly, with no idle bubble.
  - !req0 and !req1: go to IDLE.
  - req0 and cnt<MAX_BURST: stay, cnt+1.
  - req0 and cnt==MAX_BURST and req1: go to G1 (forced handover).
  - req0 and cnt==MAX_BURST and !req1: stay, cnt restarts at 1. No overflow; a lone requester holds indefinitely.
- cnt width is clog2(MAX_BURST+1). It never exceeds MAX_BURST.
- MAX_BURST=1: strict alternation each cycle while both sources request.
- Simultaneous drop of the owner's req and rise of the other's req: the handover happens on the same edge.
- Requests are level-sensitive; the arbiter never grants a source whose req is low at the deciding edge.
- out is don't-care when out_valid=0 but still equals the mux of the current sel.

Test Plan:
- Reset and idle: assert reset mid-cycle with req0=1 -> gnt0=gnt1=0, sel=0, out_valid=0 immediately. Release with no requests -> outputs unchanged for 10 cycles.
- Single source: req0=1 only, in0=8'hA5, for 12 cycles -> gnt0=1 from the cycle after req; sel=0; out=8'hA5; no gap at the 4-cycle boundaries. Drop req0 -> IDLE next edge, sel stays 0.
- Tie from IDLE: req0=req1=1 on the same edge after reset -> gnt0 first (last=1). With MAX_BURST=4 and both held: pattern 4x gnt0, 4x gnt1, 4x gnt0. out alternates between in0=8'h11 and in1=8'h22 accordingly.
- Early release: in G1, cnt=2, req1 drops while req0=1 -> next cycle gnt0=1, sel=0, cnt=1, no out_valid gap. A later tie from IDLE grants source 1 (last=0).
- Async reset during grant: in G0 with cnt=3, pulse reset for 2 ns between edges -> gnt0 falls without a clock. After release with req0=req1=1 -> gnt0 wins (last reset to 1).
- MAX_BURST=1 instance: both requesting for 8 cycles -> gnt0 and gnt1 alternate every cycle; sel toggles 0,1,0,1...; never both grants high.
